// File: rtl/ex_stage_mdu_if.sv
// Bus bundle of ex_stage_mdu: ID/EX inputs, EX/MEM output register, forwarding bus.
// master = surrounding pipeline, slave = execute stage.
interface ex_stage_mdu_if #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUSEL_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          aluin1_sel;
    logic                aluin2_sel;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     sa_ext;
    logic [ALUSEL_W-1:0] alusel;
    logic [2:0]          mdu_op;
    logic [RADDR_W-1:0]  wa;
    logic                regwe;
    logic                memwe;
    logic [2:0]          cregwd;
    logic [1:0]          memlen;
    logic                flush;
    logic                out_ready;

    logic                out_valid;
    logic [RADDR_W-1:0]  out_wa;
    logic                out_regwe;
    logic [2:0]          out_cregwd;
    logic [1:0]          out_memlen;
    logic                out_memwe;
    logic [XLEN-1:0]     out_rd2;
    logic [XLEN-1:0]     out_result;
    logic                fwd_we;
    logic [RADDR_W-1:0]  fwd_wa;
    logic [XLEN-1:0]     fwd_wd;
    logic                mdu_busy;

    modport master (
        output in_valid, aluin1_sel, aluin2_sel, rd1, rd2, imm_ext, sa_ext, alusel,
               mdu_op, wa, regwe, memwe, cregwd, memlen, flush, out_ready,
        input  in_ready, out_valid, out_wa, out_regwe, out_cregwd, out_memlen,
               out_memwe, out_rd2, out_result, fwd_we, fwd_wa, fwd_wd, mdu_busy
    );

    modport slave (
        input  in_valid, aluin1_sel, aluin2_sel, rd1, rd2, imm_ext, sa_ext, alusel,
               mdu_op, wa, regwe, memwe, cregwd, memlen, flush, out_ready,
        output in_ready, out_valid, out_wa, out_regwe, out_cregwd, out_memlen,
               out_memwe, out_rd2, out_result, fwd_we, fwd_wa, fwd_wd, mdu_busy
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand select, single-cycle ALU, iterative MULT/DIV with HI/LO, EX/MEM register.
// Define EX_MDU_DIV_EN to build the divider; otherwise DIV/DIVU retire as 1-cycle no-ops.
module ex_stage_mdu #(
    parameter int         XLEN       = 32,
    parameter int         RADDR_W    = 5,
    parameter int         ALUSEL_W   = 5,
    parameter logic [2:0] CREGWD_ALU = 3'd0
) (
    input  logic          clk,
    input  logic          rst,
    ex_stage_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MFHI  = 3'd5;
    localparam logic [2:0] MDU_MFLO  = 3'd6;

    localparam logic [ALUSEL_W-1:0] ALU_ADD  = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] ALU_SUB  = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] ALU_AND  = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] ALU_OR   = ALUSEL_W'(3);
    localparam logic [ALUSEL_W-1:0] ALU_XOR  = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] ALU_NOR  = ALUSEL_W'(5);
    localparam logic [ALUSEL_W-1:0] ALU_SLT  = ALUSEL_W'(6);
    localparam logic [ALUSEL_W-1:0] ALU_SLTU = ALUSEL_W'(7);
    localparam logic [ALUSEL_W-1:0] ALU_SLL  = ALUSEL_W'(8);
    localparam logic [ALUSEL_W-1:0] ALU_SRL  = ALUSEL_W'(9);
    localparam logic [ALUSEL_W-1:0] ALU_SRA  = ALUSEL_W'(10);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [RADDR_W-1:0] wa;
        logic               regwe;
        logic [2:0]         cregwd;
        logic [1:0]         memlen;
        logic               memwe;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    result;
    } exmem_t;

    state_t            state, state_nxt;
    logic              out_vld;
    exmem_t            out_q, ctx, new_entry, done_entry;
    logic [XLEN-1:0]   hi, lo;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   p_hi, p_lo, mcand;
    logic              neg_prod;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_hi, fin_lo;

    logic [XLEN-1:0]   op1, op2, mag1, mag2, alu_res, single_res;
    logic [SH_W-1:0]   shamt;
    logic              is_mul, is_div, is_signed, starts_iter, div_as_nop;
    logic              ready, accept, start, slot_free, retire;

`ifdef EX_MDU_DIV_EN
    logic              op_div, neg_r, div_zero, div_ge;
    logic [XLEN-1:0]   dividend;
    logic [XLEN:0]     div_shift;
`endif

    // Operand selection and ALU. Shifts move op2 by op1, so LUI is SLL with op1 = 16.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op1 = '0;
        case (bus.aluin1_sel)
            2'd0:    op1 = bus.rd1;
            2'd1:    op1 = bus.sa_ext;
            2'd2:    op1 = XLEN'(16);
            default: op1 = '0;
        endcase
        op2   = bus.aluin2_sel ? bus.imm_ext : bus.rd2;
        shamt = op1[SH_W-1:0];

        alu_res = '0;
        case (bus.alusel)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_NOR:  alu_res = ~(op1 | op2);
            ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
            ALU_SLTU: alu_res = XLEN'(op1 < op2);
            ALU_SLL:  alu_res = op2 << shamt;
            ALU_SRL:  alu_res = op2 >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op2) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    assign is_mul    = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);
    assign is_div    = (bus.mdu_op == MDU_DIV)  || (bus.mdu_op == MDU_DIVU);
    assign is_signed = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_DIV);
    assign mag1      = (is_signed && op1[XLEN-1]) ? -op1 : op1;
    assign mag2      = (is_signed && op2[XLEN-1]) ? -op2 : op2;

`ifdef EX_MDU_DIV_EN
    assign starts_iter = is_mul || is_div;
    assign div_as_nop  = 1'b0;
`else
    assign starts_iter = is_mul;
    assign div_as_nop  = is_div;
`endif

    assign slot_free = !out_vld || bus.out_ready;
    assign ready     = !rst && (state == S_IDLE) && slot_free && !bus.flush;
    assign accept    = bus.in_valid && ready;
    assign start     = accept && starts_iter;
    assign retire    = (state == S_DONE) && slot_free && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)                 state_nxt = S_BUSY;
                S_BUSY:  if (cnt == CNT_W'(1))      state_nxt = S_DONE;
                S_DONE:  if (slot_free)             state_nxt = S_IDLE;
                default:                            state_nxt = S_IDLE;
            endcase
        end
    end

    // One iteration per BUSY cycle on magnitudes: product/remainder in p_hi, multiplier/quotient in p_lo.
    always_comb begin
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        prod_fix = neg_prod ? -{p_hi, p_lo} : {p_hi, p_lo};
        fin_hi   = prod_fix[2*XLEN-1:XLEN];
        fin_lo   = prod_fix[XLEN-1:0];
`ifdef EX_MDU_DIV_EN
        div_shift = {p_hi, p_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        if (op_div) begin
            if (div_zero) begin
                fin_hi = dividend;
                fin_lo = '1;
            end else begin
                fin_hi = neg_r    ? -p_hi : p_hi;
                fin_lo = neg_prod ? -p_lo : p_lo;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            mcand    <= '0;
            neg_prod <= 1'b0;
            ctx      <= '0;
            hi       <= '0;
            lo       <= '0;
`ifdef EX_MDU_DIV_EN
            op_div   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
`endif
        end else begin
            if (start) begin
                cnt      <= CNT_W'(XLEN);
                p_hi     <= '0;
                p_lo     <= is_div ? mag1 : mag2;
                mcand    <= is_div ? mag2 : mag1;
                neg_prod <= is_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
                ctx      <= '{wa: bus.wa, regwe: 1'b0, cregwd: bus.cregwd, memlen: bus.memlen,
                              memwe: bus.memwe, rd2: bus.rd2, result: '0};
`ifdef EX_MDU_DIV_EN
                op_div   <= is_div;
                neg_r    <= is_signed && op1[XLEN-1];
                div_zero <= (op2 == '0);
                dividend <= op1;
`endif
            end else if (state == S_BUSY && !bus.flush) begin
                cnt <= cnt - CNT_W'(1);
`ifdef EX_MDU_DIV_EN
                if (op_div) begin
                    p_hi <= div_ge ? XLEN'(div_shift - {1'b0, mcand}) : div_shift[XLEN-1:0];
                    p_lo <= {p_lo[XLEN-2:0], div_ge};
                end else
`endif
                begin
                    p_hi <= mul_sum[XLEN:1];
                    p_lo <= {mul_sum[0], p_lo[XLEN-1:1]};
                end
            end
            if (retire) begin
                hi <= fin_hi;
                lo <= fin_lo;
            end
        end
    end

    always_comb begin
        case (bus.mdu_op)
            MDU_MFHI: single_res = hi;
            MDU_MFLO: single_res = lo;
            default:  single_res = div_as_nop ? '0 : alu_res;
        endcase
        new_entry = '{wa: bus.wa, regwe: bus.regwe && !div_as_nop, cregwd: bus.cregwd,
                      memlen: bus.memlen, memwe: bus.memwe, rd2: bus.rd2, result: single_res};
        done_entry        = ctx;
        done_entry.result = fin_lo;
    end

    // EX/MEM register: flush beats stall; a stalled entry is held untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (bus.flush) begin
            out_vld <= 1'b0;
        end else if (slot_free) begin
            if (state == S_DONE) begin
                out_vld <= 1'b1;
                out_q   <= done_entry;
            end else if (accept && !starts_iter) begin
                out_vld <= 1'b1;
                out_q   <= new_entry;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_vld;
    assign bus.out_wa     = out_q.wa;
    assign bus.out_regwe  = out_q.regwe;
    assign bus.out_cregwd = out_q.cregwd;
    assign bus.out_memlen = out_q.memlen;
    assign bus.out_memwe  = out_q.memwe;
    assign bus.out_rd2    = out_q.rd2;
    assign bus.out_result = out_q.result;
    assign bus.fwd_we     = out_vld && out_q.regwe;
    assign bus.fwd_wa     = out_q.wa;
    assign bus.fwd_wd     = (out_q.cregwd == CREGWD_ALU) ? out_q.result : '0;
    assign bus.mdu_busy   = (state != S_IDLE);
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Randomized self-checking bench for ex_stage_mdu against an arithmetic reference model.
// Expectations follow EX_MDU_DIV_EN the same way the design does.
module tb_ex_stage_mdu;
    localparam int XLEN = 32;
`ifdef EX_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(XLEN), .RADDR_W(5), .ALUSEL_W(5)) bus ();

    ex_stage_mdu #(.XLEN(XLEN), .RADDR_W(5), .ALUSEL_W(5), .CREGWD_ALU(3'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  s1;
        logic        s2;
        logic [31:0] rd1, rd2, imm, sa;
        logic [4:0]  alusel;
        logic [2:0]  mop;
        logic [4:0]  wa;
        logic        regwe, memwe;
        logic [2:0]  cregwd;
        logic [1:0]  memlen;
    } instr_t;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] op1_of(input instr_t t);
        case (t.s1)
            2'd0:    return t.rd1;
            2'd1:    return t.sa;
            2'd2:    return 32'd16;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] op2_of(input instr_t t);
        return t.s2 ? t.imm : t.rd2;
    endfunction

    function automatic logic [31:0] alu_model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (sel)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ~(a | b);
            5'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:    return (a < b) ? 32'd1 : 32'd0;
            5'd8:    return b << sh;
            5'd9:    return b >> sh;
            5'd10:   return 32'($signed(b) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic mdu_model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = m_hi;
        l = m_lo;
        case (mop)
            3'd1: begin up = longint'(sa * sb); {h, l} = up; end
            3'd2: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    if (mop == 3'd4) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    function automatic instr_t mk(input logic [2:0] mop, input logic [4:0] sel,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        instr_t t;
        t.s1 = 2'd0; t.s2 = 1'b0; t.rd1 = a; t.rd2 = b; t.imm = 32'd0; t.sa = 32'd0;
        t.alusel = sel; t.mop = mop; t.wa = wa; t.regwe = 1'b1; t.memwe = 1'b0;
        t.cregwd = 3'd0; t.memlen = 2'd0;
        return t;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.s1 = 2'($urandom_range(0, 3)); t.s2 = 1'($urandom_range(0, 1));
        t.rd1 = pick(); t.rd2 = pick(); t.imm = pick(); t.sa = 32'($urandom_range(0, 31));
        t.alusel = 5'($urandom_range(0, 12)); t.mop = 3'($urandom_range(0, 7));
        t.wa = 5'($urandom); t.regwe = 1'($urandom); t.memwe = 1'($urandom);
        t.cregwd = 3'($urandom_range(0, 3)); t.memlen = 2'($urandom);
        return t;
    endfunction

    task automatic drive(input instr_t t);
        bus.aluin1_sel = t.s1;  bus.aluin2_sel = t.s2;
        bus.rd1 = t.rd1;        bus.rd2 = t.rd2;
        bus.imm_ext = t.imm;    bus.sa_ext = t.sa;
        bus.alusel = t.alusel;  bus.mdu_op = t.mop;
        bus.wa = t.wa;          bus.regwe = t.regwe;
        bus.memwe = t.memwe;    bus.cregwd = t.cregwd;
        bus.memlen = t.memlen;  bus.in_valid = 1'b1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Issue one instruction, let it complete, and compare the EX/MEM entry with the model.
    task automatic run(input instr_t t);
        logic [31:0] a, b, nh, nl, exp_res;
        bit          ok, busy_bad, iter, exp_we;
        int          cyc;
        a = op1_of(t);
        b = op2_of(t);
        drive(t);
        wait_ready(ok);
        if (!ok) begin bus.in_valid = 1'b0; return; end
        tick();
        bus.in_valid = 1'b0;
        iter = (t.mop == 3'd1) || (t.mop == 3'd2) || (DIV_EN && (t.mop == 3'd3 || t.mop == 3'd4));
        if (iter) begin
            mdu_model(t.mop, a, b, nh, nl);
            cyc = 0;
            busy_bad = 1'b0;
            while (!bus.out_valid && cyc < XLEN + 8) begin
                if (bus.in_ready || !bus.mdu_busy) busy_bad = 1'b1;
                tick();
                cyc++;
            end
            check("mdu_latency", 64'(cyc), 64'(XLEN + 1));
            check("mdu_ready_low_while_busy", 64'(busy_bad), 64'd0);
            check("mdu_out_result_lo", 64'(bus.out_result), 64'(nl));
            check("mdu_out_regwe", 64'(bus.out_regwe), 64'd0);
            check("mdu_fwd_we", 64'(bus.fwd_we), 64'd0);
            m_hi = nh;
            m_lo = nl;
        end else begin
            exp_we = t.regwe;
            case (t.mop)
                3'd5:       exp_res = m_hi;
                3'd6:       exp_res = m_lo;
                3'd3, 3'd4: begin exp_res = 32'd0; exp_we = 1'b0; end
                default:    exp_res = alu_model(t.alusel, a, b);
            endcase
            check("out_valid", 64'(bus.out_valid), 64'd1);
            check("out_result", 64'(bus.out_result), 64'(exp_res));
            check("out_regwe", 64'(bus.out_regwe), 64'(exp_we));
            check("out_wa", 64'(bus.out_wa), 64'(t.wa));
            check("out_rd2", 64'(bus.out_rd2), 64'(t.rd2));
            check("out_ctrl", 64'({bus.out_cregwd, bus.out_memlen, bus.out_memwe}),
                  64'({t.cregwd, t.memlen, t.memwe}));
            check("fwd_we", 64'(bus.fwd_we), 64'(exp_we));
            check("fwd_wa", 64'(bus.fwd_wa), 64'(t.wa));
            check("fwd_wd", 64'(bus.fwd_wd), 64'((t.cregwd == 3'd0) ? exp_res : 32'd0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t ta, tb2, tf;
        bit     ok;

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(mk(3'd0, 5'd0, 32'd0, 32'd0, 5'd0));
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_outputs", 64'({bus.out_result, bus.out_wa, bus.out_regwe, bus.fwd_we, bus.fwd_wd}), 64'd0);
        check("rst_mdu_busy", 64'(bus.mdu_busy), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Directed: ADD, reset HI/LO, multiply and divide corner cases.
        run(mk(3'd0, 5'd0, 32'd5, 32'd7, 5'd3));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd1));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd2));
        run(mk(3'd1, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd3, 5'd0, -32'sd7, 32'd2, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd3, 5'd0, 32'd9, 32'd0, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd3, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd4, 5'd0, 32'd100, 32'd7, 5'd0));
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));

        // Back-pressure: the held entry must not move and nothing new is accepted.
        ta  = mk(3'd0, 5'd0, 32'd100, 32'd23, 5'd7);
        tb2 = mk(3'd0, 5'd1, 32'd50, 32'd8, 5'd9);
        drive(ta);
        wait_ready(ok);
        tick();
        bus.out_ready = 1'b0;
        drive(tb2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_result", 64'(bus.out_result), 64'd123);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("post_stall_result", 64'(bus.out_result), 64'd42);
        check("post_stall_wa", 64'(bus.out_wa), 64'd9);

        // Flush ten cycles into an iterative op: HI/LO must keep the values of the last MULT.
        run(mk(3'd1, 5'd0, 32'd1234, 32'd5678, 5'd0));
        tf = DIV_EN ? mk(3'd3, 5'd0, 32'd1000, 32'd7, 5'd0) : mk(3'd1, 5'd0, 32'd77, 32'd99, 5'd0);
        drive(tf);
        wait_ready(ok);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        check("busy_before_flush", 64'(bus.mdu_busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_mdu_busy", 64'(bus.mdu_busy), 64'd0);
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd4));

        // Reset in the middle of a multiply clears HI/LO.
        drive(mk(3'd1, 5'd0, 32'h0001_2345, 32'h0000_0777, 5'd0));
        wait_ready(ok);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("rst_mid_busy", 64'(bus.mdu_busy), 64'd0);
        run(mk(3'd5, 5'd0, 32'd0, 32'd0, 5'd4));
        run(mk(3'd6, 5'd0, 32'd0, 32'd0, 5'd4));

        for (int i = 0; i < 80; i++) run(rand_instr());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
